// File: rtl/orde_resp_rob_pkg.sv
// Shared response-path types and descriptor constants for the ordered read-response buffer.
// Also holds the aimc_lib definitions reused here: rd_t, the packet address and orde_pkt_t.
package orde_resp_rob_pkg;

    localparam int CH_NUM = 4;
    localparam int CH_W   = $clog2(CH_NUM);
    localparam int BK_W   = 4;
    localparam int ROW_W  = 14;
    localparam int COL_W  = 6;

    localparam logic [31:0] DESC_ADDR_H    = 32'h0000_0004;
    localparam logic [5:0]  DESC_MODE_A    = 6'h03;
    localparam logic [5:0]  DESC_MODE_B    = 6'h05;
    localparam int          OFFSET_WORD_LO = 2;
    localparam int          OFFSET_WORD_HI = 4;

    typedef enum logic [1:0] {
        RD_NORMAL = 2'd0,
        RD_PIM    = 2'd1,
        RD_MRS    = 2'd2,
        RD_RSVD   = 2'd3
    } rd_t;

    localparam int RD_W = $bits(rd_t);

    // Address half of a response packet; the packet is {addr_t, data}.
    typedef struct packed {
        logic [BK_W-1:0]  bk;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } addr_t;

    localparam int ADDR_W = $bits(addr_t);

    typedef struct packed {
        rd_t             rd_type;
        logic [CH_W-1:0] ch;
        addr_t           addr;
    } orde_pkt_t;

    localparam int ORDE_PKT_W = $bits(orde_pkt_t);

endpackage

// File: rtl/orde_desc_rewrite.sv
// Combinational indirect-descriptor detect and rewrite: the selected offset word
// becomes base register + offset (mod 2^32); everything else passes through.
module orde_desc_rewrite
    import orde_resp_rob_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int NUM_BASE_REGS = 4
) (
    input  logic [DATA_WIDTH-1:0]       word_in,
    input  logic [32*NUM_BASE_REGS-1:0] base_regs,
    output logic [DATA_WIDTH-1:0]       word_out
);

    logic detect;
    logic sel_hit;
    int   sel;
    int   off_word;

    assign detect = (word_in[63:32] == DESC_ADDR_H)
                 && ((word_in[5:0] == DESC_MODE_A) || (word_in[5:0] == DESC_MODE_B))
                 && word_in[23]
                 && (word_in[31:24] == 8'h00);

    always_comb begin
        sel_hit  = 1'b0;
        sel      = 0;
        // Scan downward so the lowest set selector bit of w7 wins.
        for (int j = NUM_BASE_REGS; j >= 1; j--) begin
            if (word_in[7*32 + j]) begin
                sel_hit = 1'b1;
                sel     = j - 1;
            end
        end
        off_word = (sel < 2) ? OFFSET_WORD_LO : OFFSET_WORD_HI;
        word_out = word_in;
        if (detect && word_in[0] && sel_hit) begin
            word_out[off_word*32 +: 32] = word_in[off_word*32 +: 32] + base_regs[sel*32 +: 32];
        end
    end

endmodule

// File: rtl/orde_resp_rob.sv
// Ordered read-response buffer: in-order metadata to orde with a short dedup history,
// and a two-stage data read path that rewrites indirect descriptors.
module orde_resp_rob
    import orde_resp_rob_pkg::*;
#(
    parameter int NUM_BUFFERING = 16,
    parameter int DATA_WIDTH    = 256,
    parameter int NUM_BASE_REGS = 4,
    parameter int DEDUP_DEPTH   = 2,
    parameter int RDY_MARGIN    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [RD_W-1:0]                 in_rd_type,
    input  logic [ADDR_W+DATA_WIDTH-1:0]    in_pkt,
    input  logic [CH_W-1:0]                 in_ch_addr,
    output logic [ORDE_PKT_W-1:0]           pop_pkt,
    output logic                            pop_pkt_valid,
    input  logic                            data_pop,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_out_valid,
    input  logic [32*NUM_BASE_REGS-1:0]     base_regs,
    output logic [$clog2(NUM_BUFFERING):0]  meta_cnt,
    output logic [$clog2(NUM_BUFFERING):0]  data_cnt,
    output logic                            err_underflow
);

    localparam int PTR_W     = $clog2(NUM_BUFFERING);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RDY_LIMIT = NUM_BUFFERING - RDY_MARGIN;

    orde_pkt_t             meta_mem [NUM_BUFFERING];
    logic [DATA_WIDTH-1:0] data_mem [NUM_BUFFERING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      meta_rd_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  wbuf_vld;
    logic [PTR_W-1:0]      wbuf_ptr;
    logic [DATA_WIDTH-1:0] wbuf_data;

    orde_pkt_t             stage_pkt;
    logic                  stage_vld;
    orde_pkt_t             hist [DEDUP_DEPTH];
    logic [DEDUP_DEPTH-1:0] hist_vld;

    logic [DATA_WIDTH-1:0] s1_word;
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] rw_word;

    orde_pkt_t in_meta;
    logic      ins;
    logic      stage_load;
    logic      dup;
    logic      emit;
    logic      pop_ok;
    logic      s1_load;

    assign in_meta    = '{rd_type: rd_t'(in_rd_type), ch: in_ch_addr,
                          addr: in_pkt[DATA_WIDTH +: ADDR_W]};
    assign in_ready   = (data_cnt < CNT_W'(RDY_LIMIT));
    assign ins        = in_valid && in_ready;
    // The stage is drained every cycle (emitted or dropped), so it can always refill.
    assign stage_load = (meta_cnt != '0);
    assign emit       = stage_vld && !dup;
    assign pop_ok     = data_pop && data_out_valid;
    // Data writes land one cycle after insert; hold the fetch off a slot still in flight.
    assign s1_load    = (data_cnt != '0) && !s1_vld && !data_out_valid
                     && !(wbuf_vld && (wbuf_ptr == rd_ptr));

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEDUP_DEPTH; i++) begin
            if (hist_vld[i] && (hist[i] == stage_pkt)) dup = 1'b1;
        end
    end

    orde_desc_rewrite #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_BASE_REGS (NUM_BASE_REGS)
    ) u_rewrite (
        .word_in   (s1_word),
        .base_regs (base_regs),
        .word_out  (rw_word)
    );

    always_ff @(posedge clk) begin
        if (ins) meta_mem[wr_ptr] <= in_meta;
        wbuf_ptr  <= wr_ptr;
        wbuf_data <= in_pkt[DATA_WIDTH-1:0];
        if (wbuf_vld) data_mem[wbuf_ptr] <= wbuf_data;
        if (stage_load) stage_pkt <= meta_mem[meta_rd_ptr];
        if (s1_load) s1_word <= data_mem[rd_ptr];
        if (emit) begin
            hist[0] <= stage_pkt;
            for (int i = 1; i < DEDUP_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            meta_rd_ptr    <= '0;
            rd_ptr         <= '0;
            meta_cnt       <= '0;
            data_cnt       <= '0;
            wbuf_vld       <= 1'b0;
            stage_vld      <= 1'b0;
            s1_vld         <= 1'b0;
            hist_vld       <= '0;
            pop_pkt_valid  <= 1'b0;
            pop_pkt        <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            err_underflow  <= 1'b0;
        end else begin
            if (ins) wr_ptr <= wr_ptr + 1'b1;
            wbuf_vld <= ins;

            if (stage_load) meta_rd_ptr <= meta_rd_ptr + 1'b1;
            stage_vld     <= stage_load;
            pop_pkt_valid <= emit;
            if (emit) begin
                pop_pkt     <= stage_pkt;
                hist_vld[0] <= 1'b1;
                for (int i = 1; i < DEDUP_DEPTH; i++) hist_vld[i] <= hist_vld[i-1];
            end

            case ({ins, stage_load})
                2'b10:   meta_cnt <= meta_cnt + 1'b1;
                2'b01:   meta_cnt <= meta_cnt - 1'b1;
                default: ;
            endcase

            s1_vld <= s1_load;
            if (s1_vld) begin
                data_out       <= rw_word;
                data_out_valid <= 1'b1;
            end else if (pop_ok) begin
                data_out_valid <= 1'b0;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;

            case ({ins, pop_ok})
                2'b10:   data_cnt <= data_cnt + 1'b1;
                2'b01:   data_cnt <= data_cnt - 1'b1;
                default: ;
            endcase

            if (data_pop && !data_out_valid) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_orde_resp_rob.sv
// Directed bench for orde_resp_rob: rewrite vector table, dedup, fill/drain with wrap,
// underflow and mid-stream reset.
module tb_orde_resp_rob;
    import orde_resp_rob_pkg::*;

    localparam int DW  = 256;
    localparam int NBR = 4;
    localparam int NV  = 11;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         in_valid;
    logic                         in_ready;
    logic [RD_W-1:0]              in_rd_type;
    logic [ADDR_W+DW-1:0]         in_pkt;
    logic [CH_W-1:0]              in_ch_addr;
    logic [ORDE_PKT_W-1:0]        pop_pkt;
    logic                         pop_pkt_valid;
    logic                         data_pop;
    logic [DW-1:0]                data_out;
    logic                         data_out_valid;
    logic [32*NBR-1:0]            base_regs;
    logic [4:0]                   meta_cnt;
    logic [4:0]                   data_cnt;
    logic                         err_underflow;

    always #5 clk = ~clk;

    orde_resp_rob #(
        .NUM_BUFFERING (16),
        .DATA_WIDTH    (DW),
        .NUM_BASE_REGS (NBR),
        .DEDUP_DEPTH   (2),
        .RDY_MARGIN    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd_type     (in_rd_type),
        .in_pkt         (in_pkt),
        .in_ch_addr     (in_ch_addr),
        .pop_pkt        (pop_pkt),
        .pop_pkt_valid  (pop_pkt_valid),
        .data_pop       (data_pop),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .base_regs      (base_regs),
        .meta_cnt       (meta_cnt),
        .data_cnt       (data_cnt),
        .err_underflow  (err_underflow)
    );

    typedef struct {
        string         nm;
        int            id;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [NV];
    int   n_pass  = 0;
    int   n_total = 0;
    int   pulses  = 0;

    always @(negedge clk) if (pop_pkt_valid === 1'b1) pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] mkw(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w4,
                                          input logic [31:0] w7);
        return {w7, 32'h6666_0006, 32'h5555_0005, w4, 32'h3333_0003, w2, w1, w0};
    endfunction

    function automatic logic [DW-1:0] fw(input logic [31:0] tag);
        return {8{tag}};
    endfunction

    function automatic logic [ORDE_PKT_W-1:0] exp_meta(input int id);
        return {id[1:0], id[3:2], id[7:4], id[21:8], 6'h2A};
    endfunction

    task automatic drive(input int id, input logic [DW-1:0] d);
        in_valid   = 1'b1;
        in_rd_type = id[1:0];
        in_ch_addr = id[3:2];
        in_pkt     = {id[7:4], id[21:8], 6'h2A, d};
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic pop_word(input string nm, input logic [DW-1:0] exp);
        int k = 0;
        while (data_out_valid !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        chkb({nm, "/vld"}, data_out_valid, 1'b1);
        chk({nm, "/data"}, data_out, exp);
        data_pop = 1'b1;
        step();
        data_pop = 1'b0;
    endtask

    // Single packet into an empty buffer: metadata at N+2, rewritten data at N+3.
    task automatic run_vec(input int i);
        string nm = vecs[i].nm;
        drive(vecs[i].id, vecs[i].data);
        step();
        idle();
        chk({nm, "/data_cnt_n"}, DW'(data_cnt), DW'(1));
        chk({nm, "/meta_cnt_n"}, DW'(meta_cnt), DW'(1));
        chkb({nm, "/pv_n"}, pop_pkt_valid, 1'b0);
        step();
        chkb({nm, "/pv_n1"}, pop_pkt_valid, 1'b0);
        step();
        chkb({nm, "/pv_n2"}, pop_pkt_valid, 1'b1);
        chk({nm, "/pop_pkt"}, DW'(pop_pkt), DW'(exp_meta(vecs[i].id)));
        chkb({nm, "/dv_n2"}, data_out_valid, 1'b0);
        step();
        chkb({nm, "/dv_n3"}, data_out_valid, 1'b1);
        chk({nm, "/data_out"}, data_out, vecs[i].exp);
        chkb({nm, "/pv_n3"}, pop_pkt_valid, 1'b0);
        data_pop = 1'b1;
        step();
        data_pop = 1'b0;
        chkb({nm, "/dv_pop"}, data_out_valid, 1'b0);
        chk({nm, "/data_cnt_pop"}, DW'(data_cnt), DW'(0));
    endtask

    initial begin
        int base;

        vecs[0]  = '{"single",    1,  mkw(32'h0080_0003, 32'h4, 32'h100, 32'h4444_0004, 32'h2),
                                      mkw(32'h0080_0003, 32'h4, 32'h1000_0100, 32'h4444_0004, 32'h2)};
        vecs[1]  = '{"passthru",  2,  mkw(32'h0080_0003, 32'h4, 32'h100, 32'h4444_0004, 32'h0),
                                      mkw(32'h0080_0003, 32'h4, 32'h100, 32'h4444_0004, 32'h0)};
        vecs[2]  = '{"maxwrap",   3,  mkw(32'h0080_0003, 32'h4, 32'h100, 32'hFFFF_FFF0, 32'h10),
                                      mkw(32'h0080_0003, 32'h4, 32'h100, 32'h0000_0010, 32'h10)};
        vecs[3]  = '{"modeb_k0",  4,  mkw(32'h0080_0005, 32'h4, 32'h1, 32'h2, 32'h6),
                                      mkw(32'h0080_0005, 32'h4, 32'h1000_0001, 32'h2, 32'h6)};
        vecs[4]  = '{"sel1",      5,  mkw(32'h0080_0003, 32'h4, 32'h7, 32'h9, 32'h4),
                                      mkw(32'h0080_0003, 32'h4, 32'h0000_4007, 32'h9, 32'h4)};
        vecs[5]  = '{"sel2",      6,  mkw(32'h0080_0005, 32'h4, 32'h7, 32'h5, 32'h8),
                                      mkw(32'h0080_0005, 32'h4, 32'h7, 32'h0030_0005, 32'h8)};
        vecs[6]  = '{"w1_not4",   7,  mkw(32'h0080_0003, 32'h5, 32'h100, 32'h9, 32'h2),
                                      mkw(32'h0080_0003, 32'h5, 32'h100, 32'h9, 32'h2)};
        vecs[7]  = '{"hibyte",    8,  mkw(32'h0180_0003, 32'h4, 32'h100, 32'h9, 32'h2),
                                      mkw(32'h0180_0003, 32'h4, 32'h100, 32'h9, 32'h2)};
        vecs[8]  = '{"bit23_clr", 9,  mkw(32'h0000_0003, 32'h4, 32'h100, 32'h9, 32'h2),
                                      mkw(32'h0000_0003, 32'h4, 32'h100, 32'h9, 32'h2)};
        vecs[9]  = '{"sel_range", 10, mkw(32'h0080_0003, 32'h4, 32'h100, 32'h9, 32'h20),
                                      mkw(32'h0080_0003, 32'h4, 32'h100, 32'h9, 32'h20)};
        vecs[10] = '{"bad_mode",  11, mkw(32'h0080_0007, 32'h4, 32'h100, 32'h9, 32'h2),
                                      mkw(32'h0080_0007, 32'h4, 32'h100, 32'h9, 32'h2)};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_rd_type = '0;
        in_pkt     = '0;
        in_ch_addr = '0;
        data_pop   = 1'b0;
        base_regs  = {32'h0000_0020, 32'h0030_0000, 32'h0000_4000, 32'h1000_0000};
        step();
        step();
        chk("rst/data_cnt", DW'(data_cnt), DW'(0));
        chk("rst/meta_cnt", DW'(meta_cnt), DW'(0));
        chkb("rst/pv", pop_pkt_valid, 1'b0);
        chkb("rst/dv", data_out_valid, 1'b0);
        chkb("rst/err", err_underflow, 1'b0);
        chk("rst/pop_pkt", DW'(pop_pkt), DW'(0));
        chk("rst/data_out", data_out, '0);
        chkb("rst/in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) run_vec(i);

        // Three identical metadata entries back-to-back yield one pulse; data still drains in order.
        base = pulses;
        for (int k = 0; k < 3; k++) begin
            drive(20, fw(32'hE000_0000 | k));
            step();
        end
        idle();
        repeat (5) step();
        chk("dedup/pulses", DW'(pulses - base), DW'(1));
        chk("dedup/meta_cnt", DW'(meta_cnt), DW'(0));
        chk("dedup/data_cnt", DW'(data_cnt), DW'(3));
        for (int k = 0; k < 3; k++) pop_word($sformatf("dedup/w%0d", k), fw(32'hE000_0000 | k));

        // Fill to the ready threshold and drain, twice, so both pointers wrap.
        for (int r = 0; r < 2; r++) begin
            base = pulses;
            for (int j = 0; j < 14; j++) begin
                chkb($sformatf("fill%0d/rdy%0d", r, j), in_ready, 1'b1);
                drive(100 + r*32 + j, fw(32'hD000_0000 | (r << 8) | j));
                step();
            end
            idle();
            chkb($sformatf("fill%0d/full_rdy", r), in_ready, 1'b0);
            chk($sformatf("fill%0d/data_cnt", r), DW'(data_cnt), DW'(14));
            repeat (4) step();
            chk($sformatf("fill%0d/meta_cnt", r), DW'(meta_cnt), DW'(0));
            chk($sformatf("fill%0d/pulses", r), DW'(pulses - base), DW'(14));
            pop_word($sformatf("fill%0d/w0", r), fw(32'hD000_0000 | (r << 8)));
            chkb($sformatf("fill%0d/rdy_after_pop", r), in_ready, 1'b1);
            chk($sformatf("fill%0d/cnt_after_pop", r), DW'(data_cnt), DW'(13));
            chkb($sformatf("fill%0d/dv_m", r), data_out_valid, 1'b0);
            step();
            chkb($sformatf("fill%0d/dv_m1", r), data_out_valid, 1'b0);
            step();
            chkb($sformatf("fill%0d/dv_m2", r), data_out_valid, 1'b1);
            for (int j = 1; j < 14; j++)
                pop_word($sformatf("fill%0d/w%0d", r, j), fw(32'hD000_0000 | (r << 8) | j));
            chk($sformatf("fill%0d/drained", r), DW'(data_cnt), DW'(0));
        end

        // Pop on an empty buffer is ignored and latches the sticky error.
        chkb("uf/err_before", err_underflow, 1'b0);
        data_pop = 1'b1;
        step();
        data_pop = 1'b0;
        chkb("uf/err", err_underflow, 1'b1);
        chk("uf/data_cnt", DW'(data_cnt), DW'(0));
        step();
        chkb("uf/err_sticky", err_underflow, 1'b1);

        // Reset while two packets are in flight discards everything.
        drive(200, fw(32'h7777_0000));
        step();
        drive(201, fw(32'h7777_0001));
        step();
        idle();
        step();
        chkb("mid/pv_before", pop_pkt_valid, 1'b1);
        rst_n = 1'b0;
        step();
        chkb("mid/pv", pop_pkt_valid, 1'b0);
        chk("mid/pop_pkt", DW'(pop_pkt), DW'(0));
        chkb("mid/dv", data_out_valid, 1'b0);
        chk("mid/data_out", data_out, '0);
        chk("mid/meta_cnt", DW'(meta_cnt), DW'(0));
        chk("mid/data_cnt", DW'(data_cnt), DW'(0));
        chkb("mid/err", err_underflow, 1'b0);
        chkb("mid/in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        step();
        step();
        chk("mid/empty_after", DW'(data_cnt), DW'(0));
        chkb("mid/no_ghost_dv", data_out_valid, 1'b0);
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
